// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-cache request/response bus between the MEM stage and the dcache
interface mem_access_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_we;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic [7:0]        dc_req_wmask;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_rdata;
    modport master (
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_rdata
    );
    modport slave (
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage issuing one dcache load/store at a time with lane alignment, load extension and flush handling
module mem_access_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               redirect_flush,
    input  logic               in_instr_valid,
    input  logic               in_is_load,
    input  logic               in_is_store,
    input  logic               in_is_unsigned,
    input  logic [3:0]         in_ls_size,
    input  logic [ADDR_W-1:0]  in_ls_address,
    input  logic [DATA_W-1:0]  in_store_data,
    output logic               mem_stall,
    mem_access_stage_if.master dc,
    output logic [DATA_W-1:0]  load_data,
    output logic               load_data_valid,
    output logic               misalign_exc
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [2:0]        size_q;
    logic [2:0]        off_q;
    logic              we_q;
    logic              unsigned_q;
    logic              mem_op;
    logic              misaligned;
    logic              accept;
    logic [2:0]        off;
    logic [2:0]        align_mask;
    logic [7:0]        base_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extracted;

    assign mem_op     = in_instr_valid & (in_is_load | in_is_store);
    assign off        = in_ls_address[2:0];
    // align_mask is bytes(size)-1, so it doubles as the upper bits of the byte-enable pattern
    assign align_mask = {in_ls_size[3], in_ls_size[3] | in_ls_size[2], in_ls_size[3] | in_ls_size[2] | in_ls_size[1]};
    assign misaligned = |(off & align_mask);
    assign accept     = (state == IDLE) & ~redirect_flush & mem_op & ~misaligned;
    assign base_mask  = {{4{in_ls_size[3]}}, {2{align_mask[1]}}, align_mask[0], |in_ls_size};

    assign shifted = dc.dc_resp_rdata >> {off_q, 3'b000};
    always_comb begin
        extracted = shifted;
        if (size_q[0])
            extracted = {{(DATA_W-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
        else if (size_q[1])
            extracted = {{(DATA_W-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
        else if (size_q[2])
            extracted = {{(DATA_W-32){~unsigned_q & shifted[31]}}, shifted[31:0]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? REQ : IDLE;
            REQ:     state_next = dc.dc_req_ready ? (redirect_flush ? DRAIN : WAIT) : (redirect_flush ? IDLE : REQ);
            WAIT:    state_next = dc.dc_resp_valid ? (redirect_flush ? IDLE : DONE) : (redirect_flush ? DRAIN : WAIT);
            DONE:    state_next = IDLE;
            DRAIN:   state_next = dc.dc_resp_valid ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // reset_n gates the stall so an op presented during reset cannot stall the pipe
    always_comb begin
        dc.dc_req_valid = state == REQ;
        load_data_valid = (state == DONE) & ~we_q & ~redirect_flush;
        mem_stall       = reset_n & ~redirect_flush &
                          (accept | state == REQ | state == WAIT | (state == DRAIN & in_instr_valid));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            size_q       <= '0;
            off_q        <= '0;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            load_data    <= '0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= (state == IDLE) & ~redirect_flush & mem_op & misaligned;
            if (accept) begin
                addr_q     <= {in_ls_address[ADDR_W-1:3], 3'b000};
                wdata_q    <= in_store_data << {off, 3'b000};
                wmask_q    <= base_mask << off;
                size_q     <= in_ls_size[2:0];
                off_q      <= off;
                we_q       <= in_is_store;
                unsigned_q <= in_is_unsigned;
            end
            if (state == WAIT & dc.dc_resp_valid & ~redirect_flush & ~we_q)
                load_data <= extracted;
        end
    end

    assign dc.dc_req_we    = we_q;
    assign dc.dc_req_addr  = addr_q;
    assign dc.dc_req_wdata = wdata_q;
    assign dc.dc_req_wmask = wmask_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven, directed and randomized checks of mem_access_stage against a reference model
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset_n, redirect_flush, in_instr_valid, in_is_load, in_is_store, in_is_unsigned;
    logic [3:0]  in_ls_size;
    logic [63:0] in_ls_address, in_store_data, load_data;
    logic        mem_stall, load_data_valid, misalign_exc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_load = '0;

    typedef struct {
        bit          ld;
        bit          uns;
        int          nb;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        int          rdy;
        int          rsp;
        bit          mis;
        logic [63:0] e_addr;
        logic [7:0]  e_wmask;
        logic [63:0] e_wdata;
        logic [63:0] e_load;
    } vec_t;

    mem_access_stage_if #(.ADDR_W(64), .DATA_W(64)) dc ();

    mem_access_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset_n(reset_n), .redirect_flush(redirect_flush),
        .in_instr_valid(in_instr_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_is_unsigned(in_is_unsigned), .in_ls_size(in_ls_size), .in_ls_address(in_ls_address),
        .in_store_data(in_store_data), .mem_stall(mem_stall), .dc(dc),
        .load_data(load_data), .load_data_valid(load_data_valid), .misalign_exc(misalign_exc)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] size_of(input int nb);
        return nb == 1 ? 4'b0001 : nb == 2 ? 4'b0010 : nb == 4 ? 4'b0100 : 4'b1000;
    endfunction

    task automatic drive_op(input bit ld, input bit uns, input int nb, input logic [63:0] addr, input logic [63:0] sdata);
        in_instr_valid = 1'b1;
        in_is_load     = ld;
        in_is_store    = !ld;
        in_is_unsigned = uns;
        in_ls_size     = size_of(nb);
        in_ls_address  = addr;
        in_store_data  = sdata;
    endtask

    task automatic idle_inputs();
        in_instr_valid = 1'b0;
        in_is_load     = 1'b0;
        in_is_store    = 1'b0;
    endtask

    // Reference model: expectations straight from byte-address arithmetic
    function automatic vec_t mk(input bit ld, input bit uns, input int nb, input logic [63:0] addr,
                                input logic [63:0] sdata, input logic [63:0] rdata, input int rdy, input int rsp);
        vec_t v;
        int off;
        logic [63:0] val, lim;
        off = int'(addr % 8);
        v.ld = ld; v.uns = uns; v.nb = nb; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rdy = rdy; v.rsp = rsp;
        v.mis = (addr % 64'(nb)) != 0;
        v.e_addr = addr - 64'(off);
        v.e_wmask = 8'(((64'd1 << nb) - 1) << off);
        v.e_wdata = sdata << (8 * off);
        val = rdata >> (8 * off);
        if (nb < 8) begin
            lim = 64'd1 << (8 * nb);
            val = val % lim;
            if (!uns && val >= lim / 2) val = val - lim;
        end
        v.e_load = val;
        return v;
    endfunction

    function automatic vec_t tv(input bit ld, input bit uns, input int nb, input logic [63:0] addr,
                                input logic [63:0] sdata, input logic [63:0] rdata, input int rdy, input int rsp,
                                input bit mis, input logic [63:0] ea, input logic [7:0] em,
                                input logic [63:0] ew, input logic [63:0] el);
        vec_t v;
        v.ld = ld; v.uns = uns; v.nb = nb; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rdy = rdy; v.rsp = rsp; v.mis = mis;
        v.e_addr = ea; v.e_wmask = em; v.e_wdata = ew; v.e_load = el;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int stalls = 0;
        @(negedge clock);
        drive_op(v.ld, v.uns, v.nb, v.addr, v.sdata);
        #2;
        if (v.mis) begin
            chk("mis_stall", mem_stall, 0);
            @(negedge clock);
            idle_inputs();
            #2;
            chk("mis_exc", misalign_exc, 1);
            chk("mis_req_valid", dc.dc_req_valid, 0);
            chk("mis_stall_after", mem_stall, 0);
            @(negedge clock);
            #2;
            chk("mis_exc_clear", misalign_exc, 0);
            chk("mis_req_valid_after", dc.dc_req_valid, 0);
            chk("mis_load_hold", load_data, last_load);
            return;
        end
        chk("accept_stall", mem_stall, 1);
        for (int i = 0; i <= v.rdy; i++) begin
            @(negedge clock);
            idle_inputs();
            in_ls_address = {$urandom, $urandom};
            in_store_data = {$urandom, $urandom};
            dc.dc_req_ready = (i == v.rdy);
            #2;
            stalls += int'(mem_stall);
            chk("req_valid", dc.dc_req_valid, 1);
            chk("req_addr", dc.dc_req_addr, v.e_addr);
            chk("req_we", dc.dc_req_we, !v.ld);
            if (!v.ld) begin
                chk("req_wmask", dc.dc_req_wmask, v.e_wmask);
                chk("req_wdata", dc.dc_req_wdata, v.e_wdata);
            end
        end
        for (int j = 0; j <= v.rsp; j++) begin
            @(negedge clock);
            dc.dc_req_ready  = 1'b0;
            dc.dc_resp_valid = (j == v.rsp);
            dc.dc_resp_rdata = (j == v.rsp) ? v.rdata : ~v.rdata;
            #2;
            stalls += int'(mem_stall);
            chk("wait_req_valid", dc.dc_req_valid, 0);
            chk("wait_ldv", load_data_valid, 0);
        end
        @(negedge clock);
        dc.dc_resp_valid = 1'b0;
        #2;
        chk("stall_cycles", 64'(stalls), 64'(v.rdy + v.rsp + 2));
        chk("done_stall", mem_stall, 0);
        chk("done_ldv", load_data_valid, v.ld);
        if (v.ld) begin
            chk("load_data", load_data, v.e_load);
            last_load = v.e_load;
        end else
            chk("store_keeps_load", load_data, last_load);
        @(negedge clock);
        #2;
        chk("idle_ldv", load_data_valid, 0);
        chk("idle_load_hold", load_data, last_load);
    endtask

    vec_t tbl[$];
    int   nb;
    logic [63:0] a;

    initial begin
        reset_n = 1'b0;
        redirect_flush = 1'b0;
        drive_op(1, 0, 8, 64'h100, 0);
        dc.dc_req_ready = 1'b0;
        dc.dc_resp_valid = 1'b0;
        dc.dc_resp_rdata = '0;
        repeat (2) @(negedge clock);
        #2;
        chk("rst_stall", mem_stall, 0);
        chk("rst_req_valid", dc.dc_req_valid, 0);
        chk("rst_req_we", dc.dc_req_we, 0);
        chk("rst_ldv", load_data_valid, 0);
        chk("rst_mis", misalign_exc, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_req_addr", dc.dc_req_addr, 0);
        chk("rst_req_wdata", dc.dc_req_wdata, 0);
        chk("rst_req_wmask", dc.dc_req_wmask, 0);
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;

        tbl.push_back(tv(1, 0, 1, 64'h1003, 0, 64'h0000_0000_80FF_0000, 0, 0, 0, 64'h1000, 0, 0, 64'hFFFF_FFFF_FFFF_FF80));
        tbl.push_back(tv(0, 0, 2, 64'h2006, 64'hABCD, 0, 3, 1, 0, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 0));
        tbl.push_back(tv(1, 0, 4, 64'h3002, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(tv(1, 1, 4, 64'h4004, 0, 64'h9000_0000_1234_5678, 1, 2, 0, 64'h4000, 0, 0, 64'h0000_0000_9000_0000));
        tbl.push_back(tv(1, 0, 2, 64'h5002, 0, 64'h0000_0000_8001_0000, 0, 1, 0, 64'h5000, 0, 0, 64'hFFFF_FFFF_FFFF_8001));
        tbl.push_back(tv(1, 0, 8, 64'h6000, 0, 64'hDEAD_BEEF_0123_4567, 2, 0, 0, 64'h6000, 0, 0, 64'hDEAD_BEEF_0123_4567));
        tbl.push_back(tv(0, 0, 1, 64'h7005, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 0, 64'h7000, 8'h20, 64'hBCDE_F000_0000_0000, 0));
        tbl.push_back(tv(0, 0, 8, 64'h8008, 64'h1122_3344_5566_7788, 0, 0, 2, 0, 64'h8008, 8'hFF, 64'h1122_3344_5566_7788, 0));
        tbl.push_back(tv(1, 1, 1, 64'h9007, 0, 64'hAB00_0000_0000_0000, 1, 0, 0, 64'h9000, 0, 0, 64'hAB));
        tbl.push_back(tv(0, 0, 4, 64'hA006, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(tv(1, 1, 2, 64'hB006, 0, 64'hF00D_0000_0000_0000, 0, 0, 0, 64'hB000, 0, 0, 64'hF00D));
        tbl.push_back(tv(1, 0, 4, 64'hC004, 0, 64'h8765_4321_0000_0000, 0, 0, 0, 64'hC000, 0, 0, 64'hFFFF_FFFF_8765_4321));
        foreach (tbl[i]) run_op(tbl[i]);

        // flush in the accept cycle: op is not taken
        @(negedge clock);
        drive_op(1, 0, 8, 64'hE000, 0);
        redirect_flush = 1'b1;
        #2;
        chk("flush_accept_stall", mem_stall, 0);
        @(negedge clock);
        redirect_flush = 1'b0;
        idle_inputs();
        #2;
        chk("flush_accept_noreq", dc.dc_req_valid, 0);
        chk("flush_accept_nomis", misalign_exc, 0);

        // flush in REQ before the handshake, then a stray response in IDLE
        @(negedge clock);
        drive_op(1, 0, 4, 64'hD000, 0);
        @(negedge clock);
        idle_inputs();
        redirect_flush = 1'b1;
        #2;
        chk("flushreq_valid_same", dc.dc_req_valid, 1);
        chk("flushreq_stall", mem_stall, 0);
        @(negedge clock);
        redirect_flush = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = '1;
        #2;
        chk("flushreq_dropped", dc.dc_req_valid, 0);
        chk("flushreq_idle_stall", mem_stall, 0);
        @(negedge clock);
        dc.dc_resp_valid = 1'b0;
        #2;
        chk("stray_resp_ldv", load_data_valid, 0);
        chk("stray_resp_load", load_data, last_load);

        // flush in WAIT, response 5 cycles later while a new mem op waits in DRAIN
        @(negedge clock);
        drive_op(1, 0, 8, 64'hF000, 0);
        @(negedge clock);
        idle_inputs();
        dc.dc_req_ready = 1'b1;
        @(negedge clock);
        dc.dc_req_ready = 1'b0;
        redirect_flush = 1'b1;
        #2;
        chk("flushwait_stall", mem_stall, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            redirect_flush = 1'b0;
            drive_op(1, 0, 1, 64'h0, 0);
            #2;
            chk("drain_stall", mem_stall, 1);
            chk("drain_no_req", dc.dc_req_valid, 0);
            chk("drain_ldv", load_data_valid, 0);
        end
        @(negedge clock);
        idle_inputs();
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 64'h1234_5678_9ABC_DEF0;
        #2;
        chk("drain_resp_stall", mem_stall, 0);
        chk("drain_resp_ldv", load_data_valid, 0);
        @(negedge clock);
        dc.dc_resp_valid = 1'b0;
        #2;
        chk("drain_exit_ldv", load_data_valid, 0);
        chk("drain_load_hold", load_data, last_load);

        // flush in DONE: the pulse is suppressed though the data was captured in WAIT
        @(negedge clock);
        drive_op(1, 0, 1, 64'hF001, 0);
        @(negedge clock);
        idle_inputs();
        dc.dc_req_ready = 1'b1;
        @(negedge clock);
        dc.dc_req_ready = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = 64'h0000_0000_0000_7F00;
        @(negedge clock);
        dc.dc_resp_valid = 1'b0;
        redirect_flush = 1'b1;
        #2;
        chk("flushdone_ldv", load_data_valid, 0);
        chk("flushdone_stall", mem_stall, 0);
        @(negedge clock);
        redirect_flush = 1'b0;
        #2;
        chk("flushdone_idle_ldv", load_data_valid, 0);
        chk("flushdone_load_reg", load_data, 64'h7F);
        last_load = 64'h7F;

        // asynchronous reset while in WAIT, then a late response
        @(negedge clock);
        drive_op(1, 0, 8, 64'h1_0000, 0);
        @(negedge clock);
        idle_inputs();
        dc.dc_req_ready = 1'b1;
        @(negedge clock);
        dc.dc_req_ready = 1'b0;
        drive_op(1, 0, 8, 64'h2_0000, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("wrst_stall", mem_stall, 0);
        chk("wrst_req_valid", dc.dc_req_valid, 0);
        chk("wrst_ldv", load_data_valid, 0);
        chk("wrst_mis", misalign_exc, 0);
        chk("wrst_load_data", load_data, 0);
        chk("wrst_req_addr", dc.dc_req_addr, 0);
        chk("wrst_req_wmask", dc.dc_req_wmask, 0);
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clock);
        dc.dc_resp_valid = 1'b1;
        dc.dc_resp_rdata = '1;
        #2;
        chk("late_resp_req_valid", dc.dc_req_valid, 0);
        @(negedge clock);
        dc.dc_resp_valid = 1'b0;
        #2;
        chk("late_resp_ldv", load_data_valid, 0);
        chk("late_resp_load", load_data, 0);
        last_load = '0;

        for (int k = 0; k < 60; k++) begin
            nb = 1 << $urandom_range(0, 3);
            a = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) a = a & ~64'(nb - 1);
            run_op(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb, a,
                      {$urandom, $urandom}, {$urandom, $urandom},
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: ADDR_W, default 64, width of the load/store address.
REQ-002 Parameter: DATA_W, default 64, width of the data path. Only 64 is supported.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 redirect_flush  in  1  kill the in-flight memory op.
REQ-006 in_instr_valid  in  1  EX/MEM pipe register holds a valid instruction.
REQ-007 in_is_load, in_is_store, in_is_unsigned  in  1 each  op class and extension type.
REQ-008 in_ls_size  in  4  one-hot access size: 0001 B, 0010 H, 0100 W, 1000 D.
REQ-009 in_ls_address  in  ADDR_W  effective byte address.
REQ-010 in_store_data  in  DATA_W  store source, LSB-aligned.
REQ-011 mem_stall  out  1  hold the EX/MEM pipe register.
REQ-012 dc_req_valid  out  1  request valid. dc_req_ready  in  1  request accepted.
REQ-013 dc_req_we  out  1  store (1) or load (0).
REQ-014 dc_req_addr  out  ADDR_W  8-byte-aligned address (addr[2:0] forced to 0).
REQ-015 dc_req_wdata  out  DATA_W  lane-shifted store data. dc_req_wmask  out  8  byte enables.
REQ-016 dc_resp_valid  in  1  response pulse. dc_resp_rdata  in  DATA_W  aligned 8-byte line.
REQ-017 load_data  out  DATA_W  extended load result. load_data_valid  out  1  one-cycle pulse.
REQ-018 misalign_exc  out  1  one-cycle pulse for a misaligned access.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, DONE, DRAIN.
REQ-020 A memory op is in_instr_valid & (in_is_load | in_is_store). It is accepted only in IDLE with redirect_flush=0.
REQ-021 On acceptance of an aligned op, the block SHALL latch addr, size, we, unsigned, wdata and wmask, and go to REQ. mem_stall=1 combinationally in the accept cycle.
REQ-022 An access is misaligned if addr mod bytes(size) != 0. For a misaligned op: misalign_exc pulses in the next cycle, no request is issued, mem_stall stays 0, the state stays IDLE.
REQ-023 REQ: dc_req_valid=1, and all request fields are held stable until dc_req_ready=1, then go to WAIT. The handshake completes in the same cycle as valid&ready.
REQ-024 WAIT: on dc_resp_valid go to DONE. For a load, register the extracted data.
REQ-025 DONE: load_data_valid=1 (loads only), mem_stall=0, then unconditionally go to IDLE. DONE never accepts a new op.
REQ-026 mem_stall SHALL be 1 in REQ and WAIT, and 0 in DONE.
REQ-027 wmask = (1,3,15,255 per size) << addr[2:0].
REQ-028 wdata = in_store_data << (8*addr[2:0]), truncated to 64 bits.
REQ-029 Load extract: rdata >> (8*addr[2:0]), then keep the low 8/16/32/64 bits. Sign-extend when in_is_unsigned=0, zero-extend when 1. D needs no extension.
REQ-030 dc_req_addr, wdata and wmask are don't-care when dc_req_valid=0. load_data holds its last value between pulses.
REQ-031 Flush in the accept cycle (IDLE): the op is not accepted.
REQ-032 Flush in REQ before the handshake: drop dc_req_valid the next cycle and go to IDLE. Flush in the handshake cycle is treated as WAIT.
REQ-033 Flush in WAIT: go to DRAIN (or to IDLE if dc_resp_valid arrives in the same cycle). The response is discarded and no load_data_valid is produced.
REQ-034 Flush in DONE: suppress load_data_valid and go to IDLE.
REQ-035 mem_stall SHALL be 0 in any cycle where redirect_flush=1.
REQ-036 DRAIN: mem_stall = in_instr_valid. On dc_resp_valid go to IDLE with no output pulse.
REQ-037 dc_resp_valid in IDLE, REQ or DONE is a protocol error and SHALL be ignored.

Reset
REQ-038 While reset_n=0: state=IDLE, and dc_req_valid, dc_req_we, mem_stall, load_data_valid and misalign_exc are 0. load_data, dc_req_addr, dc_req_wdata and dc_req_wmask are 0.
REQ-039 Reset deassertion mid-transaction SHALL leave no outstanding state. A pending dcache response after reset is ignored per REQ-037.

Verification
REQ-040 LB addr 0x1003 signed, ready=1 same cycle, resp 1 cycle later with rdata 0x0000_0000_80FF_0000 -> dc_req_addr=0x1000, load_data=0xFFFF_FFFF_FFFF_FF80, load_data_valid 1 cycle, mem_stall high 2 cycles.
REQ-041 SH addr 0x2006 data 0xABCD, ready delayed 3 cycles -> req fields stable 4 cycles, wmask=0xC0, wdata=0xABCD_0000_0000_0000, no load_data_valid.
REQ-042 LW addr 0x3002 -> misalign_exc pulse, dc_req_valid never 1, mem_stall 0.
REQ-043 LD issued, flush in WAIT, resp 5 cycles later -> DRAIN, mem_stall=0 in flush cycle, no load_data_valid, then IDLE.
REQ-044 LWU addr 0x4004 rdata 0x9000_0000_1234_5678 -> load_data=0x0000_0000_9000_0000.
REQ-045 reset_n low while in WAIT -> all outputs 0 immediately, IDLE, and a late dc_resp_valid produces no pulse.
